ads5404_align_pack: RTL and testbench

- Parametrised successor to the ADS5404 capture path.
- Sits after the per-channel IDDR de-interleave, in the ADC clock domain.
- Uses the ADC sync output to fix sample phase across the two DDR lanes, and to fix word boundaries.
- Packs PACK consecutive sample pairs per channel into one wide output word with a valid strobe.
- Also tracks per-channel sticky overrange flags and counts sync misalignments.

---
 rtl/ads5404_align_pack.sv | 187 ++++++++++++++++++
 tb/tb_ads5404_align_pack.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads5404_align_pack.sv
// ADS5404 capture back end: aligns the two DDR lanes on the ADC sync, then packs
// PACK sample pairs per channel into one wide word, with sticky overrange flags and a sync error count.
module ads5404_align_pack #(
  parameter int NBITS        = 12,
  parameter int NCHAN        = 2,
  parameter int PACK         = 2,
  parameter int AUTO_REALIGN = 0
) (
  input  logic                          adc_clk,
  input  logic                          user_rst,
  input  logic [NCHAN*2*NBITS-1:0]      din,
  input  logic [NCHAN*2-1:0]            ovr_in,
  input  logic [1:0]                    sync_in,
  input  logic                          arm,
  input  logic                          ovr_clr,
  output logic [NCHAN*2*PACK*NBITS-1:0] dout,
  output logic                          dout_valid,
  output logic                          dout_sync,
  output logic                          aligned,
  output logic                          slip,
  output logic [NCHAN-1:0]              ovr_sticky,
  output logic [15:0]                   sync_err_cnt
);

  localparam int WW = NCHAN * 2 * PACK * NBITS;
  localparam int BW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PACK - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, RUN} state_t;

  state_t                  state_q, state_d;
  logic                    slip_q, slip_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [NCHAN*NBITS-1:0]  prev_l1_q, prev_l1_d;
  logic [WW-1:0]           buf_q, buf_d;
  logic [WW-1:0]           word_q, word_d;
  logic                    word_valid_q, word_valid_d;
  logic                    word_sync_q, word_sync_d;
  logic                    sync_pend_q, sync_pend_d;
  logic [WW-1:0]           dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    dout_sync_q, dout_sync_d;
  logic [NCHAN-1:0]        ovr_q, ovr_d;
  logic [15:0]             err_q, err_d;

  logic                    sync_any, sync_lane, on_beat, misalign;
  logic                    pend, kill, realign, take, take_slip;
  logic [BW-1:0]           take_beat;
  logic [WW-1:0]           fill;
  logic [NBITS-1:0]        s_old, s_new;

  always_ff @(posedge adc_clk) begin
    if (user_rst) begin
      state_q      <= IDLE;
      slip_q       <= 1'b0;
      beat_q       <= '0;
      prev_l1_q    <= '0;
      buf_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      word_sync_q  <= 1'b0;
      sync_pend_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_sync_q  <= 1'b0;
      ovr_q        <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      slip_q       <= slip_d;
      beat_q       <= beat_d;
      prev_l1_q    <= prev_l1_d;
      buf_q        <= buf_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      word_sync_q  <= word_sync_d;
      sync_pend_q  <= sync_pend_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_sync_q  <= dout_sync_d;
      ovr_q        <= ovr_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    sync_any  = |sync_in;
    sync_lane = ~sync_in[0];
    // A lane-1 sync marks the older half of the next cycle's pair, so it lands on beat 0 when the current beat is the last.
    on_beat   = sync_lane ? (beat_q == LAST_BEAT) : (beat_q == '0);
    misalign  = (state_q == RUN) && sync_any && ((sync_lane != slip_q) || !on_beat);

    state_d      = state_q;
    slip_d       = slip_q;
    beat_d       = beat_q;
    buf_d        = buf_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    word_sync_d  = 1'b0;
    err_d        = err_q;
    pend         = sync_pend_q;
    kill         = 1'b0;
    realign      = 1'b0;
    take         = 1'b0;
    take_slip    = slip_q;
    take_beat    = beat_q;

    case (state_q)
      IDLE: begin
        if (arm) state_d = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (!arm && sync_any) begin
          state_d = RUN;
          realign = 1'b1;
        end
      end
      RUN: begin
        if (arm) begin
          state_d = WAIT_SYNC;
          kill    = 1'b1;
        end else if (misalign && (AUTO_REALIGN != 0)) begin
          realign = 1'b1;
        end else begin
          take = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (realign) begin
      slip_d    = sync_lane;
      pend      = 1'b1;
      beat_d    = '0;
      take      = !sync_lane;
      take_slip = 1'b0;
      take_beat = '0;
    end

    if (arm) err_d = '0;
    else if (misalign && (err_q != '1)) err_d = err_q + 16'd1;

    fill  = buf_q;
    s_old = '0;
    s_new = '0;
    for (int unsigned c = 0; c < NCHAN; c++) begin
      s_old = take_slip ? prev_l1_q[c*NBITS +: NBITS] : din[(2*c)*NBITS +: NBITS];
      s_new = take_slip ? din[(2*c)*NBITS +: NBITS]   : din[(2*c+1)*NBITS +: NBITS];
      fill[(c*2*PACK + 2*int'(take_beat))*NBITS +: NBITS]     = s_old;
      fill[(c*2*PACK + 2*int'(take_beat) + 1)*NBITS +: NBITS] = s_new;
    end

    if (take) begin
      if (take_beat == LAST_BEAT) begin
        word_d       = fill;
        word_valid_d = 1'b1;
        word_sync_d  = pend;
        pend         = 1'b0;
        beat_d       = '0;
      end else begin
        buf_d  = fill;
        beat_d = take_beat + 1'b1;
      end
    end
    sync_pend_d = pend;

    dout_valid_d = word_valid_q & ~kill;
    dout_d       = dout_valid_d ? word_q : dout_q;
    dout_sync_d  = dout_valid_d & word_sync_q;

    prev_l1_d = '0;
    ovr_d     = '0;
    for (int unsigned c = 0; c < NCHAN; c++) begin
      prev_l1_d[c*NBITS +: NBITS] = din[(2*c+1)*NBITS +: NBITS];
      ovr_d[c] = (ovr_q[c] & ~ovr_clr) | (|ovr_in[2*c +: 2]);
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign dout_sync    = dout_sync_q;
  assign aligned      = (state_q == RUN);
  assign slip         = slip_q;
  assign ovr_sticky   = ovr_q;
  assign sync_err_cnt = err_q;

endmodule

// File: tb/tb_ads5404_align_pack.sv
// Bench for ads5404_align_pack: three instances (PACK=2 static, PACK=2 auto-realign, PACK=1)
// compared each cycle with a sample-index reference model, plus directed checks.
module tb_ads5404_align_pack;

  logic        clk = 1'b0;
  logic        user_rst;
  logic [47:0] din;
  logic [3:0]  ovr_in;
  logic [1:0]  sync_in;
  logic        arm, ovr_clr;

  logic [95:0] dout_a, dout_b;
  logic [47:0] dout_c;
  logic        dout_valid_a, dout_valid_b, dout_valid_c;
  logic        dout_sync_a, dout_sync_b, dout_sync_c;
  logic        aligned_a, aligned_b, aligned_c;
  logic        slip_a, slip_b, slip_c;
  logic [1:0]  ovr_sticky_a, ovr_sticky_b, ovr_sticky_c;
  logic [15:0] err_a, err_b, err_c;

  always #5 clk = ~clk;

  ads5404_align_pack #(.NBITS(12), .NCHAN(2), .PACK(2), .AUTO_REALIGN(0)) u_a (
    .adc_clk(clk), .user_rst(user_rst), .din(din), .ovr_in(ovr_in), .sync_in(sync_in),
    .arm(arm), .ovr_clr(ovr_clr), .dout(dout_a), .dout_valid(dout_valid_a),
    .dout_sync(dout_sync_a), .aligned(aligned_a), .slip(slip_a),
    .ovr_sticky(ovr_sticky_a), .sync_err_cnt(err_a));

  ads5404_align_pack #(.NBITS(12), .NCHAN(2), .PACK(2), .AUTO_REALIGN(1)) u_b (
    .adc_clk(clk), .user_rst(user_rst), .din(din), .ovr_in(ovr_in), .sync_in(sync_in),
    .arm(arm), .ovr_clr(ovr_clr), .dout(dout_b), .dout_valid(dout_valid_b),
    .dout_sync(dout_sync_b), .aligned(aligned_b), .slip(slip_b),
    .ovr_sticky(ovr_sticky_b), .sync_err_cnt(err_b));

  ads5404_align_pack #(.NBITS(12), .NCHAN(2), .PACK(1), .AUTO_REALIGN(0)) u_c (
    .adc_clk(clk), .user_rst(user_rst), .din(din), .ovr_in(ovr_in), .sync_in(sync_in),
    .arm(arm), .ovr_clr(ovr_clr), .dout(dout_c), .dout_valid(dout_valid_c),
    .dout_sync(dout_sync_c), .aligned(aligned_c), .slip(slip_c),
    .ovr_sticky(ovr_sticky_c), .sync_err_cnt(err_c));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: words are windows of 2*PACK consecutive samples in the
  // per-channel sample stream (sample index = 2*cycle + lane).
  int          pk[3] = '{2, 2, 1};
  int          au[3] = '{0, 1, 0};
  logic [47:0] hist[0:4095];
  int          cyc = 0;
  int          m_state[3];   // 0 idle, 1 waiting for sync, 2 running
  bit          m_slip[3], m_pend[3], m_sv[3], m_ss[3], m_ov[3], m_os[3];
  longint      m_start[3];
  logic [95:0] m_sw[3], m_ow[3];
  int          m_err[3];
  logic [1:0]  m_ovr;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [11:0] samp(input int c, input longint g);
    logic [47:0] h;
    h = hist[int'(g / 2)];
    return h[(2*c + int'(g % 2))*12 +: 12];
  endfunction

  task automatic model_edge();
    logic [95:0] w;
    int          p;
    bit          kill, emit, lane, mis;
    longint      sidx;
    hist[cyc] = user_rst ? '0 : din;
    for (int i = 0; i < 3; i++) begin
      p = pk[i];
      if (user_rst) begin
        m_state[i] = 0; m_slip[i] = 0; m_start[i] = 0; m_pend[i] = 0;
        m_sv[i] = 0; m_ss[i] = 0; m_sw[i] = '0;
        m_ov[i] = 0; m_os[i] = 0; m_ow[i] = '0; m_err[i] = 0;
      end else begin
        kill = arm && (m_state[i] == 2);
        emit = 0;
        w    = '0;
        lane = (sync_in == 2'b10);
        sidx = 2 * longint'(cyc) + longint'(lane);
        if (arm) begin
          m_err[i]   = 0;
          m_state[i] = 1;
        end else if (m_state[i] == 1 && sync_in != 2'b00) begin
          m_state[i] = 2; m_slip[i] = lane; m_start[i] = sidx; m_pend[i] = 1;
        end else if (m_state[i] == 2 && sync_in != 2'b00) begin
          mis = (lane != m_slip[i]) || (((sidx - m_start[i]) % (2 * p)) != 0);
          if (mis) begin
            if (m_err[i] < 65535) m_err[i]++;
            if (au[i] != 0) begin
              m_slip[i] = lane; m_start[i] = sidx; m_pend[i] = 1;
            end
          end
        end
        if (!arm && m_state[i] == 2 && ((m_start[i] + 2*p - 1) / 2) == longint'(cyc)) begin
          for (int c = 0; c < 2; c++)
            for (int k = 0; k < 2*p; k++)
              w[(c*2*p + k)*12 +: 12] = samp(c, m_start[i] + k);
          emit = 1;
          m_start[i] += 2 * p;
        end
        m_ov[i] = m_sv[i] && !kill;
        if (m_ov[i]) begin m_ow[i] = m_sw[i]; m_os[i] = m_ss[i]; end
        else m_os[i] = 0;
        m_sv[i] = emit;
        if (emit) begin m_sw[i] = w; m_ss[i] = m_pend[i]; m_pend[i] = 0; end
        else m_ss[i] = 0;
      end
    end
    if (user_rst) m_ovr = 2'b00;
    else m_ovr = (m_ovr & ~{2{ovr_clr}}) | {|ovr_in[3:2], |ovr_in[1:0]};
    cyc++;
  endtask

  task automatic check_all();
    logic [95:0] od[3];
    logic [15:0] oe[3];
    logic [1:0]  oo[3];
    bit          ov[3], os[3], oa[3], osl[3];
    od[0] = dout_a; od[1] = dout_b; od[2] = {48'd0, dout_c};
    ov[0] = dout_valid_a; ov[1] = dout_valid_b; ov[2] = dout_valid_c;
    os[0] = dout_sync_a;  os[1] = dout_sync_b;  os[2] = dout_sync_c;
    oa[0] = aligned_a;    oa[1] = aligned_b;    oa[2] = aligned_c;
    osl[0] = slip_a;      osl[1] = slip_b;      osl[2] = slip_c;
    oe[0] = err_a;        oe[1] = err_b;        oe[2] = err_c;
    oo[0] = ovr_sticky_a; oo[1] = ovr_sticky_b; oo[2] = ovr_sticky_c;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dout[%0d]@%0d", i, cyc),       od[i],  m_ow[i]);
      chk($sformatf("dout_valid[%0d]@%0d", i, cyc), 96'(ov[i]), 96'(m_ov[i]));
      chk($sformatf("dout_sync[%0d]@%0d", i, cyc),  96'(os[i]), 96'(m_os[i]));
      chk($sformatf("aligned[%0d]@%0d", i, cyc),    96'(oa[i]), 96'(m_state[i] == 2));
      chk($sformatf("slip[%0d]@%0d", i, cyc),       96'(osl[i]), 96'(m_slip[i]));
      chk($sformatf("err_cnt[%0d]@%0d", i, cyc),    96'(oe[i]), 96'(m_err[i]));
      chk($sformatf("ovr_sticky[%0d]@%0d", i, cyc), 96'(oo[i]), 96'(m_ovr));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // ch0 ramp: lane0 = 2n, lane1 = 2n+1; ch1 is the same ramp offset by 0x800.
  task automatic ramp(input int n, input logic [1:0] s, input logic a, input logic r);
    din      = {12'(2049 + 2*n), 12'(2048 + 2*n), 12'(2*n + 1), 12'(2*n)};
    sync_in  = s;
    arm      = a;
    user_rst = r;
    step();
    sync_in  = 2'b00;
    arm      = 1'b0;
    user_rst = 1'b0;
  endtask

  initial begin
    logic [63:0] r64;
    user_rst = 1'b1; din = '0; ovr_in = '0; sync_in = '0; arm = 1'b0; ovr_clr = 1'b0;

    // Reset with random inputs, then idle without arm.
    for (int i = 0; i < 3; i++) begin
      r64 = {$urandom(), $urandom()};
      din = r64[47:0]; sync_in = 2'($urandom); ovr_in = 4'($urandom);
      step();
      chk("rst_zero", {dout_a, dout_valid_a, dout_sync_a, aligned_a, slip_a, ovr_sticky_a, err_a}, '0);
    end
    user_rst = 1'b0; ovr_in = '0;
    for (int i = 0; i < 4; i++) begin
      r64 = {$urandom(), $urandom()};
      din = r64[47:0]; sync_in = 2'($urandom);
      step();
      chk("idle_no_valid", {dout_valid_a, aligned_a, dout_valid_c, aligned_c}, '0);
    end

    // Lane-0 alignment.
    for (int n = 0; n < 14; n++) begin
      ramp(n, (n == 5) ? 2'b01 : 2'b00, n == 2, 1'b0);
      if (n == 5) chk("l0_state", {aligned_a, slip_a}, 2'b10);
      if (n == 6) begin
        chk("l0_latency", dout_valid_a, 0);
        chk("p1_word", {dout_valid_c, dout_sync_c, dout_c[23:0]}, {2'b11, 12'd11, 12'd10});
      end
      if (n == 7) chk("l0_word0", {dout_valid_a, dout_sync_a, dout_a[47:0]},
                      {2'b11, 12'd13, 12'd12, 12'd11, 12'd10});
      if (n == 8) chk("l0_gap", dout_valid_a, 0);
      if (n == 9) chk("l0_word1", {dout_valid_a, dout_sync_a, dout_a[47:0]},
                      {2'b10, 12'd17, 12'd16, 12'd15, 12'd14});
    end

    // Lane-1 alignment.
    for (int n = 0; n < 14; n++) begin
      ramp(n, (n == 5) ? 2'b10 : 2'b00, n == 2, 1'b0);
      if (n == 5) chk("l1_state", {aligned_a, slip_a}, 2'b11);
      if (n == 7) chk("l1_latency", dout_valid_a, 0);
      if (n == 8) chk("l1_word0", {dout_valid_a, dout_sync_a, dout_a[47:0]},
                      {2'b11, 12'd14, 12'd13, 12'd12, 12'd11});
      if (n == 10) chk("l1_word1", {dout_valid_a, dout_sync_a, dout_a[47:0]},
                       {2'b10, 12'd18, 12'd17, 12'd16, 12'd15});
    end

    // Misaligned sync at beat 1, then arm clears the count.
    for (int n = 0; n < 14; n++) begin
      ramp(n, (n == 5 || n == 8) ? 2'b01 : 2'b00, n == 2 || n == 12, 1'b0);
      if (n == 8) chk("mis_cnt", {err_a, err_b, err_c}, {16'd1, 16'd1, 16'd0});
      if (n == 9) begin
        chk("mis_static", {dout_valid_a, dout_sync_a, dout_a[47:0]},
            {2'b10, 12'd17, 12'd16, 12'd15, 12'd14});
        chk("mis_dropped", dout_valid_b, 0);
      end
      if (n == 10) chk("mis_realign", {dout_valid_b, dout_sync_b, dout_b[47:0]},
                       {2'b11, 12'd19, 12'd18, 12'd17, 12'd16});
      if (n == 12) chk("arm_clears_cnt", {err_a, err_b}, '0);
    end

    // Sticky overrange.
    ovr_in = 4'b1000; step();
    chk("ovr_set", ovr_sticky_a, 2'b10);
    ovr_in = 4'b0001; ovr_clr = 1'b1; step();
    chk("ovr_set_wins", ovr_sticky_a, 2'b01);
    ovr_in = 4'b0000; step();
    chk("ovr_clr", ovr_sticky_a, 2'b00);
    ovr_clr = 1'b0;

    // Mid-run reset during beat 1, ignored syncs, then re-arm.
    for (int n = 0; n < 20; n++) begin
      logic [1:0] s;
      s = 2'b00;
      if (n == 5) s = 2'b10;
      if (n >= 8 && n <= 11) s = 2'($urandom_range(1, 3));
      if (n == 14) s = 2'b01;
      ramp(n, s, n == 2 || n == 12, n == 7);
      if (n == 6) chk("pre_rst", {aligned_a, slip_a}, 2'b11);
      if (n == 7) chk("post_rst", {dout_valid_a, aligned_a, slip_a}, 3'b000);
      if (n == 11) chk("rst_ignores_sync", {aligned_a, dout_valid_a}, 2'b00);
      if (n == 16) chk("rearm_word", {dout_valid_a, dout_sync_a, dout_a[47:0]},
                       {2'b11, 12'd31, 12'd30, 12'd29, 12'd28});
    end

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      r64      = {$urandom(), $urandom()};
      din      = r64[47:0];
      user_rst = ($urandom_range(0, 199) == 0);
      sync_in  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      arm      = ($urandom_range(0, 39) == 0);
      ovr_in   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      ovr_clr  = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
